demux4_buf: RTL and testbench
=============================

// Module: demux4_buf
// PURPOSE
//  - 1-to-4 demultiplexer with per-output one-entry buffers; the inverse of the 4:1 mux path.
//  - Routes one WIDTH-bit word per accepted transfer to the output channel chosen by {sel2,sel1}.
//  - Sits between a single producer and four independent consumers.
//  - Decouples them with a valid/ready handshake on every side.
// PARAMETERS
//  - WIDTH  8  data width of input and of each output channel
//  - CNT_W  8  width of per-channel delivery counters (used only when DEMUX4_COUNT_EN is defined)
// PORTS
//  - clk        in   1        rising-edge clock
//  - reset      in   1        asynchronous, active-high reset
//  - in         in   WIDTH    input data word
//  - in_valid   in   1        producer offers `in` this cycle
//  - in_ready   out  1        block accepts `in` this cycle (combinational)
//  - sel1       in   1        channel select, LSB; sampled with `in`
//  - sel2       in   1        channel select, MSB; sampled with `in`
//  - out1..out4 out  WIDTH    channel k buffered data (registered)
//  - valid1..4  out  1        channel k buffer holds a word (registered)
//  - ready1..4  in   1        consumer k takes the word this cycle
//  - cnt1..cnt4 out  CNT_W    words delivered on channel k (only with DEMUX4_COUNT_EN)
// BEHAVIOUR
//  - Reset is async and active-high.
//    - While reset=1: all validk=0, all outk=0, all cntk=0.
//    - in_ready reads 0 while reset=1.
//  - Select decode, same encoding as mux4: sel2,sel1 = 00->ch1, 01->ch2, 10->ch3, 11->ch4.
//  - Accept = in_valid & in_ready; the selected channel is s.
//  - in_ready = !valids | readys.
//    - A full channel that drains in the same cycle accepts a new word (no bubble).
//  - Channel k register update per clock edge (priority order):
//    - load_k (accept & s==k): outk<=in, validk<=1 (even if draining same edge).
//    - else drain_k (validk & readyk): validk<=0; outk holds last value.
//    - else: hold.
//  - Latency: accepted word appears on outk/validk one cycle after the accept edge.
//  - Channels are independent; stalls on one channel never block the others.
//    - Blocking happens only while s selects the stalled channel.
//  - Non-accepted channels are unaffected by in/sel changes.
//  - outk is stable while validk=1 and readyk=0.
//  - sel1/sel2/in are don't-care when in_valid=0.
//  - Reset asserted mid-transfer discards all buffered words immediately (async).
//    - No partial state survives reset.
//  - Each channel is a 2-state machine: EMPTY (validk=0) <-> FULL (validk=1).
//    - EMPTY->FULL on load_k.
//    - FULL->EMPTY on drain_k & !load_k.
//    - FULL->FULL on load_k with or without drain.
// CONFIGURATION
//  - `DEMUX4_COUNT_EN` defined:
//    - cntk increments by 1 on each drain_k edge.
//    - Counts wrap modulo 2^CNT_W (2^CNT_W-1 -> 0).
//    - cntk is cleared by reset only.
//  - `DEMUX4_COUNT_EN` undefined:
//    - cnt1..cnt4 ports and counter logic are absent.
//    - Data path behaviour is identical.
// TESTING
//  - Reset: assert reset mid-cycle with valid2=1 -> valid1..4=0, outs=0, in_ready=0 immediately.
//  - Routing: in=8'hA5, valid=1, sel2,sel1=10 -> next cycle out3=A5, valid3=1; valid1/2/4 stay 0.
//  - Backpressure:
//    - ch1 full, ready1=0, sel=00 -> in_ready=0 and out1 is held.
//    - Same state with sel=01 -> in_ready=1 and ch2 loads.
//  - Full throughput: ready4=1 held, in_valid=1, sel=11, in=1,2,3,4 on consecutive cycles
//    -> in_ready=1 every cycle; out4 = 1,2,3,4 on the following cycles; valid4 stays 1.
//  - Simultaneous drain+load on ch2: out2=0x11, ready2=1, new in=0x22 -> out2=0x22, valid2=1.
//  - Counter (DEMUX4_COUNT_EN, CNT_W=8): 257 drains on ch1 -> cnt1=1; cnt2..cnt4 unchanged.

Source files
------------

// File: rtl/demux4_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : demux4_buf_if
// Brief    : Bundle of producer-side and consumer-side signals of demux4_buf.
//            slave  = the demultiplexer itself
//            master = the producer plus the four consumers
//            The cnt1..cnt4 signals exist only when DEMUX4_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface demux4_buf_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);

  // Producer side
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic             sel1;
  logic             sel2;

  // Consumer side, one buffered channel per consumer
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [WIDTH-1:0] out4;
  logic             valid1;
  logic             valid2;
  logic             valid3;
  logic             valid4;
  logic             ready1;
  logic             ready2;
  logic             ready3;
  logic             ready4;

`ifdef DEMUX4_COUNT_EN
  // Per-channel delivery counters
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;
  logic [CNT_W-1:0] cnt4;
`endif

  // Reject degenerate widths when the bundle is elaborated
  if (WIDTH < 1) begin : g_width_chk
    $error("demux4_buf_if: WIDTH must be at least 1");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("demux4_buf_if: CNT_W must be at least 1");
  end

  modport slave (
    input  in, in_valid, sel1, sel2,
    input  ready1, ready2, ready3, ready4,
    output in_ready,
    output out1, out2, out3, out4,
    output valid1, valid2, valid3, valid4
`ifdef DEMUX4_COUNT_EN
    ,
    output cnt1, cnt2, cnt3, cnt4
`endif
  );

  modport master (
    output in, in_valid, sel1, sel2,
    output ready1, ready2, ready3, ready4,
    input  in_ready,
    input  out1, out2, out3, out4,
    input  valid1, valid2, valid3, valid4
`ifdef DEMUX4_COUNT_EN
    ,
    input  cnt1, cnt2, cnt3, cnt4
`endif
  );

endinterface : demux4_buf_if
`default_nettype wire

// File: rtl/demux4_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux4_buf
// Brief    : 1-to-4 demultiplexer with a one-entry buffer per output channel.
//            One word per accepted transfer is routed to the channel chosen
//            by {sel2,sel1} (00->ch1, 01->ch2, 10->ch3, 11->ch4).
//            Every side uses a valid/ready handshake; a stalled channel only
//            blocks the producer while the select points at it.
//            Optional feature macro: DEMUX4_COUNT_EN adds per-channel
//            delivery counters cnt1..cnt4 (CNT_W bits, wrap-around).
// Revision : 1.0 - initial release
// ============================================================================
module demux4_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  demux4_buf_if.slave bus
);

  // Channel buffer states
  localparam logic [0:0] c_st_empty = 1'b0;
  localparam logic [0:0] c_st_full  = 1'b1;

  // Number of output channels
  localparam int unsigned c_nch = 4;

  logic [1:0]                   w_sel;
  logic [c_nch-1:0]             w_ready;
  logic [c_nch-1:0]             w_valid;
  logic [c_nch-1:0]             w_load;
  logic [c_nch-1:0]             w_drain;
  logic [c_nch-1:0][WIDTH-1:0]  w_out;
  logic                         w_in_ready;
  logic                         w_accept;
`ifdef DEMUX4_COUNT_EN
  logic [c_nch-1:0][CNT_W-1:0]  w_cnt;
`endif

  // Reject degenerate widths at elaboration
  if (WIDTH < 1) begin : g_width_chk
    $error("demux4_buf: WIDTH must be at least 1");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("demux4_buf: CNT_W must be at least 1");
  end

  // Gather the scalar interface signals into vectors indexed by channel
  assign w_sel   = {bus.sel2, bus.sel1};
  assign w_ready = {bus.ready4, bus.ready3, bus.ready2, bus.ready1};

  // Producer may transfer when the selected buffer is empty or is being
  // drained this very cycle (no bubble on a full channel); forced low in reset.
  always_comb begin
    w_in_ready = 1'b0;
    if (!reset) begin
      w_in_ready = !w_valid[w_sel] || w_ready[w_sel];
    end
  end

  assign w_accept = bus.in_valid & w_in_ready;

  // --------------------------------------------------------------------------
  // One independent buffer per output channel
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < c_nch; k++) begin : g_ch

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;

    assign w_valid[k] = (r_state == c_st_full);
    assign w_load[k]  = w_accept && (w_sel == 2'(k));
    assign w_drain[k] = w_valid[k] && w_ready[k];
    assign w_out[k]   = r_data;

    // EMPTY/FULL tracking: a load wins over a simultaneous drain
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= c_st_empty;
      end else begin
        case (r_state)
          c_st_empty: if (w_load[k])  r_state <= c_st_full;
          c_st_full:  if (!w_load[k] && w_drain[k]) r_state <= c_st_empty;
          default:    r_state <= c_st_empty;
        endcase
      end
    end

    // Data capture only on a load; the last word is kept after a drain
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data <= '0;
      end else if (w_load[k]) begin
        r_data <= bus.in;
      end
    end

`ifdef DEMUX4_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    assign w_cnt[k] = r_cnt;

    // Count every word handed to consumer k; wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_drain[k]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
`endif

  end : g_ch

  // --------------------------------------------------------------------------
  // Drive the interface outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready = w_in_ready;

  assign bus.out1   = w_out[0];
  assign bus.out2   = w_out[1];
  assign bus.out3   = w_out[2];
  assign bus.out4   = w_out[3];

  assign bus.valid1 = w_valid[0];
  assign bus.valid2 = w_valid[1];
  assign bus.valid3 = w_valid[2];
  assign bus.valid4 = w_valid[3];

`ifdef DEMUX4_COUNT_EN
  assign bus.cnt1   = w_cnt[0];
  assign bus.cnt2   = w_cnt[1];
  assign bus.cnt3   = w_cnt[2];
  assign bus.cnt4   = w_cnt[3];
`endif

endmodule : demux4_buf
`default_nettype wire

// File: tb/tb_demux4_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4_buf
// Brief    : Self-checking bench for demux4_buf. A per-channel scoreboard
//            queue receives each accepted word and is popped when the
//            consumer takes the word; directed checks cover reset, routing,
//            backpressure, full throughput, drain+load and (with
//            DEMUX4_COUNT_EN) counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_demux4_buf;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic reset;

  demux4_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel-indexed views of the bus
  logic [3:0]       v;
  logic [WIDTH-1:0] o [4];
  logic [3:0]       rdy;

  assign v    = {bus.valid4, bus.valid3, bus.valid2, bus.valid1};
  assign o[0] = bus.out1;
  assign o[1] = bus.out2;
  assign o[2] = bus.out3;
  assign o[3] = bus.out4;
  assign bus.ready1 = rdy[0];
  assign bus.ready2 = rdy[1];
  assign bus.ready3 = rdy[2];
  assign bus.ready4 = rdy[3];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [WIDTH-1:0] sb_q [4][$];
  logic [CNT_W-1:0] mcnt [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [WIDTH-1:0] data);
    bus.in_valid = vld;
    {bus.sel2, bus.sel1} = sel;
    bus.in = data;
  endtask

  // Scoreboard monitor: samples 1 ns before each rising edge
  always begin
    logic [1:0] s;
    @(negedge clk);
    #4;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        sb_q[k].delete();
        mcnt[k] = '0;
      end
    end else begin
      s = {bus.sel2, bus.sel1};
      for (int k = 0; k < 4; k++)
        chk($sformatf("sb_valid%0d", k + 1), 32'(v[k]), 32'(sb_q[k].size() != 0));
      chk("sb_in_ready", 32'(bus.in_ready), 32'((sb_q[s].size() == 0) || rdy[s]));
      for (int k = 0; k < 4; k++) begin
        if (v[k] && rdy[k]) begin
          mcnt[k] = mcnt[k] + CNT_W'(1);
          if (sb_q[k].size() == 0) chk($sformatf("sb_extra%0d", k + 1), 32'd1, 32'd0);
          else chk($sformatf("sb_out%0d", k + 1), 32'(o[k]), 32'(sb_q[k].pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q[s].push_back(bus.in);
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    rdy   = 4'h0;
    drive(1'b1, 2'b00, 8'hFF);
    for (int k = 0; k < 4; k++) mcnt[k] = '0;

    // ---- Reset state ----
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(v), 32'h0);
    chk("rst_out1", 32'(o[0]), 32'h0);
    chk("rst_out4", 32'(o[3]), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 8'h00);

    // ---- Routing to ch3 ----
    @(negedge clk);
    drive(1'b1, 2'b10, 8'hA5);
    #1 chk("route_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00);
    #1;
    chk("route_out3", 32'(o[2]), 32'hA5);
    chk("route_valids", 32'(v), 32'b0100);
    rdy = 4'b0100;
    @(negedge clk);
    rdy = 4'h0;
    #1 chk("route_drained", 32'(v), 32'h0);

    // ---- Backpressure on ch1 ----
    @(negedge clk);
    drive(1'b1, 2'b00, 8'h3C);
    @(negedge clk);
    drive(1'b1, 2'b00, 8'h77);
    #1;
    chk("bp_in_ready_ch1", 32'(bus.in_ready), 32'h0);
    chk("bp_out1", 32'(o[0]), 32'h3C);
    @(negedge clk);
    #1 chk("bp_out1_held", 32'(o[0]), 32'h3C);
    drive(1'b1, 2'b01, 8'h77);
    #1 chk("bp_in_ready_ch2", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00);
    #1;
    chk("bp_out2", 32'(o[1]), 32'h77);
    chk("bp_valids", 32'(v), 32'b0011);
    chk("bp_out1_still", 32'(o[0]), 32'h3C);
    rdy = 4'hF;
    @(negedge clk);
    rdy = 4'h0;

    // ---- Full throughput on ch4 ----
    @(negedge clk);
    rdy[3] = 1'b1;
    drive(1'b1, 2'b11, 8'd1);
    #1 chk("tp_in_ready1", 32'(bus.in_ready), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b1, 2'b11, 8'(i));
      #1;
      chk($sformatf("tp_in_ready%0d", i), 32'(bus.in_ready), 32'h1);
      chk($sformatf("tp_out4_%0d", i - 1), 32'(o[3]), 32'(i - 1));
      chk($sformatf("tp_valid4_%0d", i - 1), 32'(v[3]), 32'h1);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00);
    #1;
    chk("tp_out4_4", 32'(o[3]), 32'd4);
    chk("tp_valid4_4", 32'(v[3]), 32'h1);
    @(negedge clk);
    rdy = 4'h0;
    #1 chk("tp_empty", 32'(v), 32'h0);

    // ---- Simultaneous drain and load on ch2 ----
    @(negedge clk);
    drive(1'b1, 2'b01, 8'h11);
    @(negedge clk);
    drive(1'b1, 2'b01, 8'h22);
    rdy[1] = 1'b1;
    #1;
    chk("dl_out2_old", 32'(o[1]), 32'h11);
    chk("dl_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00);
    rdy[1] = 1'b0;
    #1;
    chk("dl_out2_new", 32'(o[1]), 32'h22);
    chk("dl_valid2", 32'(v[1]), 32'h1);
    @(negedge clk);
    rdy = 4'hF;
    @(negedge clk);
    rdy = 4'h0;

    // ---- Random traffic, scoreboard-checked ----
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
      rdy = 4'($urandom);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00);
    rdy = 4'hF;
    repeat (3) @(negedge clk);
    #1 chk("sb_leftover", 32'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()), 32'd0);
`ifdef DEMUX4_COUNT_EN
    chk("cnt1_model", 32'(bus.cnt1), 32'(mcnt[0]));
    chk("cnt2_model", 32'(bus.cnt2), 32'(mcnt[1]));
    chk("cnt3_model", 32'(bus.cnt3), 32'(mcnt[2]));
    chk("cnt4_model", 32'(bus.cnt4), 32'(mcnt[3]));
`endif
    rdy = 4'h0;

    // ---- Asynchronous reset mid-transfer ----
    @(negedge clk);
    drive(1'b1, 2'b01, 8'h5A);
    @(negedge clk);
    #1 chk("ar_valid2_before", 32'(v[1]), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(v), 32'h0);
    chk("ar_out2", 32'(o[1]), 32'h0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 8'h00);

`ifdef DEMUX4_COUNT_EN
    // ---- Counter wrap: 257 drains on ch1 ----
    @(negedge clk);
    rdy = 4'b0001;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 2'b00, 8'(i));
      @(negedge clk);
    end
    drive(1'b0, 2'b00, 8'h00);
    @(negedge clk);
    #1;
    chk("cnt1_wrap", 32'(bus.cnt1), 32'd1);
    chk("cnt2_idle", 32'(bus.cnt2), 32'd0);
    chk("cnt3_idle", 32'(bus.cnt3), 32'd0);
    chk("cnt4_idle", 32'(bus.cnt4), 32'd0);
    rdy = 4'h0;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_demux4_buf
`default_nettype wire
